// File: rtl/sample_frame_loader.sv
// -----------------------------------------------------------------------------
// sample_frame_loader
//
// Collects N serial samples into one parallel frame and then holds that frame
// stable for a downstream adder stage until the adder acknowledges it.
//
// Ports
//   clk          in   clock; every state update happens on its rising edge
//   rst          in   synchronous reset, active-low
//   in_valid     in   upstream sample valid
//   in_data      in   [DW-1:0] upstream sample
//   in_ready     out  loader can accept a sample (high exactly while filling)
//   frame_abort  in   discard the partially filled frame (ignored while holding)
//   frame_data   out  [N*DW-1:0] parallel frame, slot k at [k*DW +: DW],
//                     slot 0 holds the first sample accepted
//   frame_valid  out  frame complete and held stable
//   frame_ack    in   adder stage finished with the frame
//   frame_cnt    out  [7:0] frames released by ack, mod 256
//   ref_sum      out  [DW+4:0] running sum of the current frame
//                     (only when SAMPLE_FRAME_LOADER_REFSUM_EN is defined)
//
// Configuration
//   SAMPLE_FRAME_LOADER_REFSUM_EN  compiles in the ref_sum port and accumulator.
// -----------------------------------------------------------------------------
module sample_frame_loader #(
    parameter int DW = 8,   // sample width in bits
    parameter int N  = 30   // samples per frame, 2..30
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    input  logic            frame_abort,
    output logic [N*DW-1:0] frame_data,
    output logic            frame_valid,
    input  logic            frame_ack,
    output logic [7:0]      frame_cnt
`ifdef SAMPLE_FRAME_LOADER_REFSUM_EN
    ,
    output logic [DW+4:0]   ref_sum
`endif
);

    // Five extra bits cover the sum of up to 32 full-scale samples.
    localparam int SW = DW + 5;
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [N-1:0][DW-1:0]    slots_q, slots_d;
    logic                    frame_valid_q, frame_valid_d;
    logic [7:0]              frame_cnt_q, frame_cnt_d;
`ifdef SAMPLE_FRAME_LOADER_REFSUM_EN
    logic [SW-1:0]           ref_sum_q, ref_sum_d;
`endif

    // Ready is a pure decode of the state so the upstream sees it the same
    // cycle the loader returns to FILL.
    assign in_ready    = (state_q == FILL);
    assign frame_data  = slots_q;
    assign frame_valid = frame_valid_q;
    assign frame_cnt   = frame_cnt_q;
`ifdef SAMPLE_FRAME_LOADER_REFSUM_EN
    assign ref_sum     = ref_sum_q;
`endif

    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a variable
        // unassigned; without these defaults synthesis infers latches.
        state_d       = state_q;
        idx_d         = idx_q;
        slots_d       = slots_q;
        frame_valid_d = frame_valid_q;
        frame_cnt_d   = frame_cnt_q;
`ifdef SAMPLE_FRAME_LOADER_REFSUM_EN
        ref_sum_d     = ref_sum_q;
`endif

        case (state_q)
            FILL: begin
                if (frame_abort) begin
                    // Abort wins over a beat arriving in the same cycle; slot
                    // contents are left alone and simply get overwritten later.
                    idx_d = '0;
`ifdef SAMPLE_FRAME_LOADER_REFSUM_EN
                    ref_sum_d = '0;
`endif
                end else if (in_valid) begin
                    slots_d[idx_q] = in_data;
`ifdef SAMPLE_FRAME_LOADER_REFSUM_EN
                    // The first beat of a frame restarts the sum instead of
                    // adding to the previous frame's total.
                    ref_sum_d = ((idx_q == '0) ? '0 : ref_sum_q) + SW'(in_data);
`endif
                    if (idx_q == LAST_IDX) begin
                        idx_d         = '0;
                        state_d       = HOLD;
                        frame_valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            HOLD: begin
                // Samples and aborts are ignored here; only ack releases the frame.
                if (frame_ack && frame_valid_q) begin
                    state_d       = FILL;
                    frame_valid_d = 1'b0;
                    frame_cnt_d   = frame_cnt_q + 8'd1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= FILL;
            idx_q         <= '0;
            // NOTE: the frame register is reset even though it is wide, because
            // the downstream stage must see an all-zero frame after reset.
            slots_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= '0;
`ifdef SAMPLE_FRAME_LOADER_REFSUM_EN
            ref_sum_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed from the previous cycle's state.
            state_q       <= state_d;
            idx_q         <= idx_d;
            slots_q       <= slots_d;
            frame_valid_q <= frame_valid_d;
            frame_cnt_q   <= frame_cnt_d;
`ifdef SAMPLE_FRAME_LOADER_REFSUM_EN
            ref_sum_q     <= ref_sum_d;
`endif
        end
    end

endmodule
